// File: rtl/stq_pkg.sv
// Shared store-queue types: drain FSM states, entry layout, size codes.
// Entry field widths here set the default address/data widths of the STQ.
package stq_pkg;

    localparam int STQ_ADDR_W = 32;
    localparam int STQ_DATA_W = 32;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    typedef enum logic {
        DRAIN_EMPTY,
        DRAIN_FULL
    } drain_state_e;

    typedef struct packed {
        logic [STQ_ADDR_W-1:0] addr;
        logic [STQ_DATA_W-1:0] data;
        logic [1:0]            size;
    } stq_entry_t;

endpackage

// File: rtl/stq_commit_drain.sv
// In-order STQ drain: reads committed entries at the head, issues them to
// the D-cache write port and returns each freed index to the allocator.
module stq_commit_drain
    import stq_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int INDEX      = 4,
    parameter int ADDR_WIDTH = STQ_ADDR_W,
    parameter int DATA_WIDTH = STQ_DATA_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            commitCnt_i,
    output logic [INDEX-1:0]      stqRdAddr_o,
    input  logic [ADDR_WIDTH-1:0] stqAddr_i,
    input  logic [DATA_WIDTH-1:0] stqData_i,
    input  logic [1:0]            stqSize_i,
    output logic                  dcWrValid_o,
    output logic [ADDR_WIDTH-1:0] dcWrAddr_o,
    output logic [DATA_WIDTH-1:0] dcWrData_o,
    output logic [1:0]            dcWrSize_o,
    input  logic                  dcWrReady_i,
    output logic                  stqFreeValid_o,
    output logic [INDEX-1:0]      stqFreeIdx_o,
    output logic [INDEX:0]        pendingCnt_o,
    output logic                  drainEmpty_o,
    output logic                  commitOvf_o
);

    drain_state_e     state_q;
    drain_state_e     state_d;
    logic [INDEX-1:0] head_q;
    logic [INDEX:0]   pend_q;
    stq_entry_t       out_q;
    logic [INDEX-1:0] idx_q;
    logic             free_valid_q;
    logic [INDEX-1:0] free_idx_q;
    logic             ovf_q;

    logic             load;
    logic             xfer;
    logic [INDEX+1:0] pend_sum;
    logic             pend_ovf;

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        xfer    = 1'b0;
        unique case (state_q)
            DRAIN_EMPTY: begin
                if (pend_q != '0) begin
                    load    = 1'b1;
                    state_d = DRAIN_FULL;
                end
            end
            DRAIN_FULL: begin
                if (dcWrReady_i) begin
                    xfer    = 1'b1;
                    load    = (pend_q != '0);
                    state_d = load ? DRAIN_FULL : DRAIN_EMPTY;
                end
            end
            default: state_d = DRAIN_EMPTY;
        endcase
    end

    // One extra bit so a commit beyond DEPTH is visible before saturating.
    assign pend_sum = {1'b0, pend_q}
                    + (INDEX+2)'(commitCnt_i)
                    - (INDEX+2)'(load);
    assign pend_ovf = pend_sum > (INDEX+2)'(DEPTH);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= DRAIN_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q       <= '0;
            pend_q       <= '0;
            out_q        <= '0;
            idx_q        <= '0;
            free_valid_q <= 1'b0;
            free_idx_q   <= '0;
            ovf_q        <= 1'b0;
        end else begin
            if (load) begin
                out_q.addr <= stqAddr_i;
                out_q.data <= stqData_i;
                out_q.size <= stqSize_i;
                idx_q      <= head_q;
                head_q     <= head_q + 1'b1;
            end
            pend_q       <= pend_ovf ? (INDEX+1)'(DEPTH)
                                     : pend_sum[INDEX:0];
            ovf_q        <= ovf_q | pend_ovf;
            free_valid_q <= xfer;
            if (xfer) begin
                free_idx_q <= idx_q;
            end
        end
    end

    assign stqRdAddr_o    = head_q;
    assign dcWrValid_o    = (state_q == DRAIN_FULL);
    assign dcWrAddr_o     = out_q.addr;
    assign dcWrData_o     = out_q.data;
    assign dcWrSize_o     = out_q.size;
    assign stqFreeValid_o = free_valid_q;
    assign stqFreeIdx_o   = free_idx_q;
    assign pendingCnt_o   = pend_q;
    assign drainEmpty_o   = (pend_q == '0) && (state_q == DRAIN_EMPTY);
    assign commitOvf_o    = ovf_q;

endmodule
